// File: rtl/vga_frame_ctrl.sv
// vga_frame_ctrl
// Purpose: generates VGA raster timing (640x480@60 Hz by default) from sys_clk
// with a CLK_DIV pixel divider. It also derives the camera block index from the
// character's absolute Y. The division runs during vertical blanking, and the
// result is committed only at frame start, so camera_y never changes mid-frame.
//
// Ports:
//   sys_clk      in   system clock (only clock in the block)
//   sys_rst_n    in   asynchronous active-low reset
//   char_abs_y   in   character absolute Y [PHY_WIDTH]
//   x, y         out  pixel / line counters [SCREEN_WIDTH]
//   video_on     out  registered: high inside the visible area
//   hsync/vsync  out  registered active-low sync pulses
//   p_tick       out  one-sys_clk pixel strobe
//   frame_start  out  one-sys_clk pulse on the (last,last)->(0,0) pixel tick
//   camera_y     out  committed camera block index [CAM_WIDTH]
module vga_frame_ctrl #(
  parameter int CLK_DIV      = 4,
  parameter int H_VISIBLE    = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int SCREEN_WIDTH = 10,
  parameter int PHY_WIDTH    = 14,
  parameter int BLOCK_WIDTH  = 480,
  parameter int CAM_WIDTH    = 5
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [PHY_WIDTH-1:0]    char_abs_y,
  output logic [SCREEN_WIDTH-1:0] x,
  output logic [SCREEN_WIDTH-1:0] y,
  output logic                    video_on,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    p_tick,
  output logic                    frame_start,
  output logic [CAM_WIDTH-1:0]    camera_y
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]        DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [SCREEN_WIDTH-1:0] X_LAST    = SCREEN_WIDTH'(H_TOTAL - 1);
  localparam logic [SCREEN_WIDTH-1:0] Y_LAST    = SCREEN_WIDTH'(V_TOTAL - 1);
  localparam logic [SCREEN_WIDTH-1:0] X_VIS     = SCREEN_WIDTH'(H_VISIBLE);
  localparam logic [SCREEN_WIDTH-1:0] Y_VIS     = SCREEN_WIDTH'(V_VISIBLE);
  localparam logic [SCREEN_WIDTH-1:0] Y_VIS_END = SCREEN_WIDTH'(V_VISIBLE - 1);
  localparam logic [SCREEN_WIDTH-1:0] HS_FIRST  = SCREEN_WIDTH'(H_VISIBLE + H_FP);
  localparam logic [SCREEN_WIDTH-1:0] HS_LAST   = SCREEN_WIDTH'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [SCREEN_WIDTH-1:0] VS_FIRST  = SCREEN_WIDTH'(V_VISIBLE + V_FP);
  localparam logic [SCREEN_WIDTH-1:0] VS_LAST   = SCREEN_WIDTH'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [PHY_WIDTH-1:0]    BLOCK     = PHY_WIDTH'(BLOCK_WIDTH);
  localparam logic [CAM_WIDTH-1:0]    Q_MAX     = {CAM_WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} cam_state_t;

  logic [DIV_W-1:0]        div_cnt;
  logic [SCREEN_WIDTH-1:0] x_next;
  logic [SCREEN_WIDTH-1:0] y_next;
  logic                    x_wrap;
  logic                    y_wrap;
  logic                    snapshot;

  cam_state_t           state;
  cam_state_t           state_next;
  logic [PHY_WIDTH-1:0] rem;
  logic [CAM_WIDTH-1:0] q;
  logic                 div_more;
  logic                 load;
  logic                 step;
  logic                 commit;

  // ---------------------------------------------------------------- timing
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign p_tick      = (div_cnt == DIV_LAST);
  assign x_wrap      = (x == X_LAST);
  assign y_wrap      = (y == Y_LAST);
  assign frame_start = p_tick && x_wrap && y_wrap;

  // Counter values that the next pixel tick will load.
  always_comb begin
    x_next = x + 1'b1;
    y_next = y;
    if (x_wrap) begin
      x_next = '0;
      y_next = y_wrap ? '0 : y + 1'b1;
    end
  end

  // The sync and video_on registers are computed from x_next and y_next. As a
  // result, they line up with the counters they describe on the same edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x        <= '0;
      y        <= '0;
      video_on <= 1'b0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
    end else if (p_tick) begin
      x        <= x_next;
      y        <= y_next;
      video_on <= (x_next < X_VIS) && (y_next < Y_VIS);
      hsync    <= !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
      vsync    <= !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
    end
  end

  // ---------------------------------------------------------------- camera
  // The snapshot is taken on the tick that loads (0, V_VISIBLE), which is the
  // first blanked line.
  assign snapshot = p_tick && x_wrap && (y == Y_VIS_END);
  assign div_more = (rem >= BLOCK) && (q != Q_MAX);

  // State and datapath registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      rem      <= '0;
      q        <= '0;
      camera_y <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        rem <= char_abs_y;
        q   <= '0;
      end else if (step) begin
        // Cannot underflow: a step only happens when rem >= BLOCK.
        rem <= rem - BLOCK;
        q   <= q + 1'b1;
      end
      if (commit) begin
        camera_y <= q;
      end
    end
  end

  // Next-state logic. A frame_start that arrives while DIVIDE is still running
  // is ignored, and the FSM still finishes into DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (snapshot)    state_next = DIVIDE;
      DIVIDE:  if (!div_more)   state_next = DONE;
      DONE:    if (frame_start) state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Datapath controls.
  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    commit = 1'b0;
    case (state)
      IDLE:    load   = snapshot;
      DIVIDE:  step   = div_more;
      DONE:    commit = frame_start;
      default: ;
    endcase
  end

endmodule
